// File: rtl/lc3b_types.sv
// -----------------------------------------------------------------------------
// lc3b_types
// Types shared by the L1 cache controllers of the LC-3b core.
//   lc3b_L1_index : set index of the 8-set, 2-way L1 (3 bits)
//   lc3b_L1_tag   : L1 tag (9 bits)
//   icache_state  : controller states, shared with the dcache controller
//   icache_way    : names one of the two ways of a set
// -----------------------------------------------------------------------------
package lc3b_types;

   typedef logic [2:0] lc3b_L1_index;
   typedef logic [8:0] lc3b_L1_tag;

   // The invalidate sweep ends once this set has been cleared.
   localparam lc3b_L1_index LastSet = 3'd7;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      ALLOCATE
   } icache_state;

   typedef enum logic {
      WAY_A = 1'b0,
      WAY_B = 1'b1
   } icache_way;

endpackage

// File: rtl/icache_victim_sel.sv
// -----------------------------------------------------------------------------
// icache_victim_sel
// Chooses which way of the indexed set gets replaced on a miss.
// Ports:
//   i_valid_A, i_valid_B : valid bits of the indexed set
//   i_lru                : LRU bit of the indexed set (1 means way B is LRU)
//   o_victim             : way to be filled
// -----------------------------------------------------------------------------
module icache_victim_sel
   import lc3b_types::*;
(
   input  logic      i_valid_A,
   input  logic      i_valid_B,
   input  logic      i_lru,
   output icache_way o_victim
);

   // Empty ways are always used before anything valid is evicted; with both
   // ways valid the LRU bit decides.
   always_comb begin
      if (!i_valid_A) begin
         o_victim = WAY_A;
      end else if (!i_valid_B) begin
         o_victim = WAY_B;
      end else if (!i_lru) begin
         o_victim = WAY_A;
      end else begin
         o_victim = WAY_B;
      end
   end

endmodule

// File: rtl/icache_control.sv
// -----------------------------------------------------------------------------
// icache_control
// Control FSM of the 2-way, 8-set LC-3b instruction cache. It clears all sets
// after reset, answers hits in the same cycle, and fills a victim way from L2
// on a miss. The arrays and the index override mux live in the datapath.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   icache_read / icache_resp           : pipeline fetch request / response
//   hit_A, hit_B                        : way-hit flags from the datapath
//   valid_A/B_dataout, lru_dataout      : state of the indexed set
//   valid/tag/data_A/B_write, lru_write : array write strobes
//   valid_A/B_datain, lru_datain        : array write data
//   index_override, init_index          : sweep index selection for datapath
//   L2_read / L2_resp                   : line-fill handshake with L2
// -----------------------------------------------------------------------------
module icache_control
   import lc3b_types::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         icache_read,
   output logic         icache_resp,
   input  logic         hit_A,
   input  logic         hit_B,
   input  logic         valid_A_dataout,
   input  logic         valid_B_dataout,
   input  logic         lru_dataout,
   output logic         valid_A_write,
   output logic         valid_B_write,
   output logic         tag_A_write,
   output logic         tag_B_write,
   output logic         data_A_write,
   output logic         data_B_write,
   output logic         lru_write,
   output logic         valid_A_datain,
   output logic         valid_B_datain,
   output logic         lru_datain,
   output logic         index_override,
   output lc3b_L1_index init_index,
   output logic         L2_read,
   input  logic         L2_resp
);

   icache_state  r_state;
   icache_state  w_nextState;
   lc3b_L1_index r_initIndex;
   icache_way    r_victimWay;
   icache_way    w_victimSel;
   logic         w_hit;

   assign w_hit = hit_A | hit_B;

   icache_victim_sel u_victimSel (
      .i_valid_A (valid_A_dataout),
      .i_valid_B (valid_B_dataout),
      .i_lru     (lru_dataout),
      .o_victim  (w_victimSel)
   );

   // State, sweep counter and victim register. The victim is captured in the
   // miss cycle because the datapath's valid/lru view of the set is only
   // guaranteed while we are still in IDLE. The sweep counter wraps back to 0
   // after set 7, which is where it must sit for the next sweep anyway.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= INIT;
         r_initIndex <= '0;
         r_victimWay <= WAY_A;
      end else begin
         r_state <= w_nextState;
         if (r_state == INIT) begin
            r_initIndex <= r_initIndex + 3'd1;
         end
         if ((r_state == IDLE) && icache_read && !w_hit) begin
            r_victimWay <= w_victimSel;
         end
      end
   end

   // Next-state logic. Once a fill has been requested it runs to completion
   // regardless of icache_read, since L2 cannot abort a transaction.
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         INIT:     if (r_initIndex == LastSet) w_nextState = IDLE;
         IDLE:     if (icache_read && !w_hit) w_nextState = ALLOCATE;
         ALLOCATE: if (L2_resp) w_nextState = IDLE;
         default:  w_nextState = INIT;
      endcase
   end

   // Output logic. Outputs are combinational so a hit answers in the cycle it
   // is requested. While reset is high everything is held quiet except the
   // index override, so the datapath already points at set 0. A hit on both
   // ways can only come from a corrupted tag array and is resolved as way A.
   always_comb begin
      icache_resp    = 1'b0;
      valid_A_write  = 1'b0;
      valid_B_write  = 1'b0;
      tag_A_write    = 1'b0;
      tag_B_write    = 1'b0;
      data_A_write   = 1'b0;
      data_B_write   = 1'b0;
      lru_write      = 1'b0;
      valid_A_datain = 1'b0;
      valid_B_datain = 1'b0;
      lru_datain     = 1'b0;
      index_override = 1'b0;
      init_index     = '0;
      L2_read        = 1'b0;
      if (reset) begin
         index_override = 1'b1;
      end else begin
         unique case (r_state)
            INIT: begin
               index_override = 1'b1;
               init_index     = r_initIndex;
               valid_A_write  = 1'b1;
               valid_B_write  = 1'b1;
               lru_write      = 1'b1;
            end
            IDLE: begin
               if (icache_read && w_hit) begin
                  icache_resp = 1'b1;
                  lru_write   = 1'b1;
                  lru_datain  = hit_A;
               end
            end
            ALLOCATE: begin
               if (L2_resp) begin
                  lru_write = 1'b1;
                  if (r_victimWay == WAY_A) begin
                     valid_A_write  = 1'b1;
                     tag_A_write    = 1'b1;
                     data_A_write   = 1'b1;
                     valid_A_datain = 1'b1;
                     lru_datain     = 1'b1;
                  end else begin
                     valid_B_write  = 1'b1;
                     tag_B_write    = 1'b1;
                     data_B_write   = 1'b1;
                     valid_B_datain = 1'b1;
                     lru_datain     = 1'b0;
                  end
               end else begin
                  L2_read = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/icache_control.md
ICACHE_CONTROL -- requirements
Module: icache_control

Interface
REQ-001 SHALL have port clk, input, 1, system clock; every state change occurs on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port icache_read, input, 1, fetch request from the pipeline; the requester holds icache_address stable while it is high.
REQ-004 SHALL have port icache_resp, output, 1, one-cycle pulse that marks icache_rdata valid for the current address.
REQ-005 SHALL have ports hit_A and hit_B, input, 1 each, way-hit flags from the datapath.
REQ-006 SHALL have ports valid_A_dataout, valid_B_dataout and lru_dataout, input, 1 each, the state of the indexed set.
REQ-007 SHALL have ports valid_A_write, valid_B_write, tag_A_write, tag_B_write, data_A_write, data_B_write and lru_write, output, 1 each, datapath array write strobes.
REQ-008 SHALL have ports valid_A_datain, valid_B_datain and lru_datain, output, 1 each, array write data.
REQ-009 SHALL have port index_override, output, 1; when high the datapath indexes its arrays with init_index instead of the address set field.
REQ-010 SHALL have port init_index, output, 3, set index used during the invalidate sweep.
REQ-011 SHALL have port L2_read, output, 1, line-fill request to L2; it is held until L2_resp.
REQ-012 SHALL have port L2_resp, input, 1, one-cycle pulse meaning L2_rdata holds the requested 128-bit line.

Function
REQ-013 SHALL implement the states INIT, IDLE and ALLOCATE.
REQ-014 INIT SHALL step init_index from 0 to 7, one set per cycle, and in each cycle:
- assert index_override;
- write valid_A, valid_B and lru to 0.
REQ-015 INIT SHALL go to IDLE after set 7 is cleared, which takes exactly 8 cycles; icache_resp and L2_read SHALL stay 0 throughout INIT, and icache_read SHALL be ignored.
REQ-016 In IDLE with icache_read=1 and (hit_A or hit_B), the block SHALL assert icache_resp combinationally in the same cycle (zero-cycle hit latency).
REQ-017 On that same hit cycle the block SHALL pulse lru_write with:
- lru_datain=1 on a hit_A (way B becomes LRU);
- lru_datain=0 on a hit_B.
REQ-018 In IDLE with icache_read=1 and no hit, the block SHALL latch the victim way into a register and go to ALLOCATE; icache_resp SHALL stay 0.
REQ-019 The victim SHALL be selected in this priority order:
- way A if valid_A_dataout=0;
- otherwise way B if valid_B_dataout=0;
- otherwise way A if lru_dataout=0, else way B.
REQ-020 ALLOCATE SHALL assert L2_read in every cycle until the cycle in which L2_resp=1.
REQ-021 In the L2_resp cycle the block SHALL, for the victim way only:
- pulse data, tag and valid write with valid datain=1;
- pulse lru_write, with lru_datain pointing at the non-victim way;
- go to IDLE.
REQ-022 After a fill, the re-lookup in IDLE SHALL hit and return icache_resp. Miss latency is 2 cycles plus the L2 latency, counted from the miss cycle to the resp cycle.
REQ-023 If icache_read drops during ALLOCATE, the block SHALL still complete the fill, because L2 transactions are not abortable.
REQ-024 hit_A and hit_B both high (an illegal state) SHALL be treated as hit_A.
REQ-025 No array write strobe SHALL be asserted in IDLE without a hit, or in ALLOCATE before L2_resp.
REQ-026 At most one way's tag, data and valid strobes SHALL be active in any cycle.

Reset
REQ-027 Reset SHALL force state INIT and init_index=0, and clear the victim register.
REQ-028 Reset asserted mid-ALLOCATE SHALL deassert L2_read in the next cycle and restart the sweep; any L2_resp arriving during INIT SHALL be ignored.
REQ-029 During reset, every output except index_override SHALL be 0; index_override SHALL be 1.

Structure
REQ-030 lc3b_types SHALL hold:
- lc3b_L1_index (3 bits);
- lc3b_L1_tag (9 bits);
- the icache_state enum (INIT, IDLE, ALLOCATE), shared with the future dcache controller.
REQ-031 The control block SHALL contain no datapath arrays; the index override mux SHALL be added to the datapath.
REQ-032 Victim selection SHALL be one combinational sub-module, icache_victim_sel; everything else SHALL be a single FSM with next-state and output always blocks.

Verification
REQ-033 Reset then idle -> index_override=1 for exactly 8 cycles with init_index 0..7, valid_A/valid_B/lru writes of 0 each cycle, then IDLE.
REQ-034 Cold miss, address 0x0040, L2 latency 5 -> L2_read high for 5 cycles, way A filled with valid=1 and lru=1, icache_resp 7 cycles after the miss cycle.
REQ-035 Hit on way B at set 3 -> icache_resp in the same cycle, lru_write=1 with lru_datain=0, no other strobes.
REQ-036 Set 2 full with lru=1, miss at tag 0x1AB -> way B replaced, lru_datain=0, way A untouched.
REQ-037 Reset asserted in the 3rd cycle of ALLOCATE -> L2_read=0 the next cycle, the 8-cycle sweep runs again, and a late L2_resp causes no writes.
REQ-038 icache_read dropped mid-ALLOCATE -> fill completes, and no icache_resp is issued until icache_read returns.
